// File: rtl/keypad_pkg.sv
// keypad_pkg: types and helpers shared by the keypad scanner and its bus glue.
//   keypad_state_e    - scanner FSM states (idle / scanning rows / key held)
//   keypad_code_width - width of a key code for a given number of keys
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StPressed
    } keypad_state_e;

    // Never returns 0 so a 1-key matrix still has a usable code field.
    function automatic int unsigned keypad_code_width(input int unsigned n_keys);
        return (n_keys > 1) ? int'($clog2(n_keys)) : 1;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: synchronous event FIFO for the keypad scanner.
// Ports:
//   HCLK, HRESETn  clock, async active-low reset (empties the FIFO)
//   push, push_data  write request and data
//   pop            remove head; ignored while empty
//   head           current head entry, 0 when empty
//   full, empty    occupancy flags
//   overflow       one-cycle pulse when a push is dropped
// DEPTH must be a power of two so the pointers wrap naturally.
module keypad_evt_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO still succeeds.
    assign push_ok  = push & (~full | pop_ok);
    assign overflow = push & ~push_ok;
    assign head     = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: ROWS x COLS matrix keypad scanner with debounce and event FIFO.
// All logic runs on HCLK; the scan rate comes from a clock-enable tick every SCAN_DIV cycles.
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   key_col        column sense, active-low, asynchronous (synchronised internally)
//   key_row        row drive, active-low
//   evt_valid      event FIFO not empty
//   evt_code       head key code = row*COLS + col, 0 when empty
//   evt_rel        head event is a release
//   evt_pop        pop head event
//   irq            level interrupt, equal to evt_valid
//   ovf, ovf_clr   sticky dropped-event flag and its clear
// Build option: define KEYPAD_RELEASE_EVT_EN to also queue release events.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int unsigned ROWS       = 4,
    parameter  int unsigned COLS       = 4,
    parameter  int unsigned SCAN_DIV   = 1048576,
    parameter  int unsigned DEBOUNCE   = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CODE_W     = keypad_code_width(ROWS * COLS)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [COLS-1:0]   key_col,
    output logic [ROWS-1:0]   key_row,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_rel,
    input  logic              evt_pop,
    output logic              irq,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE);

    // Column synchroniser; resets to "no key" (pulled-up lines).
    logic [COLS-1:0] col_meta_q, col_sync_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= key_col;
            col_sync_q <= col_meta_q;
        end
    end

    logic col_idle;
    assign col_idle = &col_sync_q;

    // Scan tick generator.
    logic [DIV_W-1:0] div_q;
    logic             tick;
    assign tick = (div_q == DIV_W'(SCAN_DIV - 1));
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) div_q <= '0;
        else          div_q <= tick ? '0 : div_q + 1'b1;
    end

    // Lowest-index low column wins when several keys share the scanned row.
    logic [CW-1:0] col_sel;
    always_comb begin
        col_sel = '0;
        for (int i = int'(COLS) - 1; i >= 0; i--) begin
            if (!col_sync_q[i]) col_sel = CW'(i);
        end
    end

    keypad_state_e  state_q, state_d;
    logic [DB_W-1:0] db_q, db_d, db_inc;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;

    assign db_inc = db_q + 1'b1;

    // State register (datapath registers ride along).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            db_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state logic; everything advances only on tick.
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        row_d   = row_q;
        col_d   = col_q;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (col_idle) begin
                        db_d = '0;
                    end else if (db_inc == DB_LAST) begin
                        db_d    = '0;
                        row_d   = '0;
                        state_d = StScan;
                    end else begin
                        db_d = db_inc;
                    end
                end
                StScan: begin
                    if (!col_idle) begin
                        col_d   = col_sel;
                        db_d    = '0;
                        state_d = StPressed;
                    end else if (row_q != RW'(ROWS - 1)) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    if (!col_idle) begin
                        db_d = '0;
                    end else if (db_inc == DB_LAST) begin
                        db_d    = '0;
                        state_d = StIdle;
                    end else begin
                        db_d = db_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs: row drive and event push requests.
    logic push, push_rel;
    always_comb begin
        key_row  = '1;
        push     = 1'b0;
        push_rel = 1'b0;
        unique case (state_q)
            StIdle:    key_row = '0;
            StScan:    key_row = ~(ROWS'(1) << row_q);
            StPressed: key_row = ~(ROWS'(1) << row_q);
            default:   key_row = '0;
        endcase
        if (tick && state_q == StScan && !col_idle) push = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
        if (tick && state_q == StPressed && col_idle && db_inc == DB_LAST) begin
            push     = 1'b1;
            push_rel = 1'b1;
        end
`endif
    end

    // Press uses the column found this tick; release reuses the latched one.
    logic [CW-1:0]     push_col;
    logic [CODE_W-1:0] push_code;
    assign push_col  = push_rel ? col_q : col_sel;
    assign push_code = CODE_W'(32'(row_q) * COLS + 32'(push_col));

    logic [CODE_W:0] fifo_head;
    logic            fifo_empty, fifo_ovf, unused_full;

    keypad_evt_fifo #(
        .WIDTH (CODE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .push      (push),
        .push_data ({push_rel, push_code}),
        .pop       (evt_pop),
        .head      (fifo_head),
        .full      (unused_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    assign evt_valid = ~fifo_empty;
    assign irq       = evt_valid;
    assign evt_code  = fifo_head[CODE_W-1:0];
`ifdef KEYPAD_RELEASE_EVT_EN
    assign evt_rel = fifo_head[CODE_W];
`else
    logic unused_head_rel;
    assign unused_head_rel = fifo_head[CODE_W];
    assign evt_rel         = 1'b0;
`endif

    // Sticky overflow; a new drop beats a clear in the same cycle.
    logic ovf_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     ovf_q <= 1'b0;
        else if (fifo_ovf) ovf_q <= 1'b1;
        else if (ovf_clr)  ovf_q <= 1'b0;
    end
    assign ovf = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4).
// A combinational key model pulls a column low when its key is held and its row is driven.
module tb_keypad_matrix_scanner;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned DIV  = 4;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       evt_rel;
    logic       evt_pop = 1'b0;
    logic       irq;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    logic [15:0] keys = '0;   // bit r*4+c = key (r,c) held

    int checks = 0;
    int errors = 0;

    keypad_matrix_scanner #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SCAN_DIV   (DIV),
        .DEBOUNCE   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .key_col   (key_col),
        .key_row   (key_row),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_rel   (evt_rel),
        .evt_pop   (evt_pop),
        .irq       (irq),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 HCLK = ~HCLK;

    always_comb begin
        key_col = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge HCLK);
    endtask

    task automatic pop_evt();
        @(negedge HCLK) evt_pop = 1'b1;
        @(negedge HCLK) evt_pop = 1'b0;
    endtask

    task automatic press_release(input int idx, input int hold, input int rel);
        keys[idx] = 1'b1;
        wait_ticks(hold);
        keys[idx] = 1'b0;
        wait_ticks(rel);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row"},   32'(key_row),   32'h0);
        check({tag, "_valid"}, 32'(evt_valid), 32'h0);
        check({tag, "_code"},  32'(evt_code),  32'h0);
        check({tag, "_rel"},   32'(evt_rel),   32'h0);
        check({tag, "_irq"},   32'(irq),       32'h0);
        check({tag, "_ovf"},   32'(ovf),       32'h0);
    endtask

    initial begin
        int n_cyc;
        repeat (3) @(negedge HCLK);
        check_reset_vals("rst");
        HRESETn = 1'b1;
        wait_ticks(3);

        // 1: hold (2,1) for 20 ticks -> single press event code 9
        keys[9] = 1'b1;
        wait_ticks(20);
        check("t1_row_held", 32'(key_row),   32'hb);
        check("t1_valid",    32'(evt_valid), 32'h1);
        check("t1_code",     32'(evt_code),  32'd9);
        check("t1_rel",      32'(evt_rel),   32'h0);
        check("t1_irq",      32'(irq),       32'h1);
        keys[9] = 1'b0;
        wait_ticks(6);
        check("t1_row_idle", 32'(key_row), 32'h0);
`ifdef KEYPAD_RELEASE_EVT_EN
        pop_evt();
        check("t1_rel_code", 32'(evt_code), 32'd9);
        check("t1_rel_flag", 32'(evt_rel),  32'h1);
`endif
        pop_evt();
        check("t1_pop_valid", 32'(evt_valid), 32'h0);
        check("t1_pop_irq",   32'(irq),       32'h0);
        check("t1_pop_code",  32'(evt_code),  32'h0);

        // 2: one-tick glitch is rejected
        keys[5] = 1'b1;
        repeat (DIV) @(negedge HCLK);
        keys[5] = 1'b0;
        wait_ticks(4);
        check("t2_valid", 32'(evt_valid), 32'h0);
        check("t2_row",   32'(key_row),   32'h0);

        // 3: six press/release cycles of (3,3) overflow the FIFO
        for (int i = 0; i < 6; i++) press_release(15, 10, 5);
        check("t3_ovf", 32'(ovf), 32'h1);
        @(negedge HCLK) ovf_clr = 1'b1;
        @(negedge HCLK) ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_valid%0d", i), 32'(evt_valid), 32'h1);
            check($sformatf("t3_code%0d", i),  32'(evt_code),  32'd15);
`ifdef KEYPAD_RELEASE_EVT_EN
            check($sformatf("t3_rel%0d", i), 32'(evt_rel), 32'(i % 2));
`else
            check($sformatf("t3_rel%0d", i), 32'(evt_rel), 32'h0);
`endif
            pop_evt();
        end
        check("t3_empty", 32'(evt_valid), 32'h0);

        // 4: (0,1) and (0,2) together -> lowest column reported
        keys[1] = 1'b1;
        keys[2] = 1'b1;
        wait_ticks(10);
        keys[1] = 1'b0;
        keys[2] = 1'b0;
        wait_ticks(5);
        check("t4_valid", 32'(evt_valid), 32'h1);
        check("t4_code",  32'(evt_code),  32'd1);
        check("t4_rel",   32'(evt_rel),   32'h0);
        pop_evt();
`ifdef KEYPAD_RELEASE_EVT_EN
        check("t4_rel_code", 32'(evt_code), 32'd1);
        pop_evt();
`endif
        check("t4_empty", 32'(evt_valid), 32'h0);

`ifdef KEYPAD_RELEASE_EVT_EN
        // 5: press then release of (0,0)
        press_release(0, 8, 5);
        check("t5_p_valid", 32'(evt_valid), 32'h1);
        check("t5_p_code",  32'(evt_code),  32'd0);
        check("t5_p_rel",   32'(evt_rel),   32'h0);
        pop_evt();
        check("t5_r_valid", 32'(evt_valid), 32'h1);
        check("t5_r_code",  32'(evt_code),  32'd0);
        check("t5_r_rel",   32'(evt_rel),   32'h1);
        pop_evt();
        check("t5_empty", 32'(evt_valid), 32'h0);
        n_cyc = 1;
`else
        n_cyc = 2;
`endif

        // 6: reset while scanning with two events queued
        for (int i = 0; i < n_cyc; i++) press_release(4, 8, 5);
        check("t6_pre_valid", 32'(evt_valid), 32'h1);
        check("t6_pre_code",  32'(evt_code),  32'd4);
        keys[15] = 1'b1;
        for (int i = 0; i < 200 && key_row != 4'b1110; i++) @(negedge HCLK);
        check("t6_in_scan", 32'(key_row), 32'he);
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        check_reset_vals("t6_rst");
        keys[15] = 1'b0;
        HRESETn  = 1'b1;
        wait_ticks(4);
        check("t6_post_valid", 32'(evt_valid), 32'h0);
        check("t6_post_row",   32'(key_row),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
